alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Round-robin arbiter and sequencer that shares the single combinational ALU among NUM_REQ requesters, e.g. the issue port and a secondary/debug issue port.
- Each requester issues with a valid/ready handshake.
- The winner drives the ALU for one cycle. The ALU result is registered into a single response slot, tagged with the requester ID, and returned through a valid/ready handshake.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID tag (derived, do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_op_i  in  NUM_REQ x milano_pkg::alu_opt_e  operator per requester.
- req_a_i  in  NUM_REQ x 32  operand A per requester.
- req_b_i  in  NUM_REQ x 32  operand B per requester.
- req_rd_addr_i  in  NUM_REQ x 5  destination register per requester.
- req_rd_we_i  in  NUM_REQ  destination write enable per requester.
- alu_operator_o  out  milano_pkg::alu_opt_e  to ALU operator input.
- alu_operand_a_o  out  32  to ALU operand A.
- alu_operand_b_o  out  32  to ALU operand B.
- alu_rd_addr_o  out  5  to ALU rd address.
- alu_rd_wr_en_o  out  1  to ALU rd write enable.
- alu_reg_we_i  in  1  from ALU write enable.
- alu_wr_addr_i  in  5  from ALU write address.
- alu_wdata_i  in  32  from ALU result.
- rsp_valid_o  out  1  response slot full.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_id_o  out  ID_W  requester that issued the response.
- rsp_we_o  out  1  registered ALU reg_we.
- rsp_addr_o  out  5  registered ALU write address.
- rsp_wdata_o  out  32  registered ALU result.

Behaviour:
- Reset (async, rst_i=1): rsp_valid_o=0; rsp_id_o=0; rsp_we_o=0; rsp_addr_o=0; rsp_wdata_o=0; rr pointer=0. All req_ready_o=0 while in reset. Reset mid-transaction drops any pending response; there is no replay.
- Slot free: slot_free = !rsp_valid_o || rsp_ready_i. Pass-through drain and refill in the same cycle is allowed.
- Arbitration (combinational):
  - Among asserted req_valid_i, search starting at rr pointer and wrapping at NUM_REQ-1 → 0; the first hit wins.
  - req_ready_o[winner] = slot_free; all other req_ready_o bits are 0.
  - req_ready_o never depends on rsp_valid_o alone when rsp_ready_i=1.
- ALU drive:
  - With a winner, alu_* outputs mirror the winner's req_* fields.
  - With no winner or !slot_free: operator=ALU_ADD, operands=0, rd_addr=0, rd_wr_en=0.
- Capture: on issue (req_valid_i & req_ready_o for the winner), at the next clk_i edge:
  - rsp_valid_o←1, rsp_id_o←winner, rsp_we_o←alu_reg_we_i, rsp_addr_o←alu_wr_addr_i, rsp_wdata_o←alu_wdata_i.
  - Issue-to-response latency is exactly 1 cycle.
- Pointer update: on issue, rr pointer←winner+1 (wraps to 0 after NUM_REQ-1). No issue → pointer holds.
- Drain: rsp_valid_o & rsp_ready_i with no new issue → rsp_valid_o←0 next edge. Other rsp_* fields hold their last value.
- Backpressure: rsp_valid_o=1 & rsp_ready_i=0 → no grant; the response fields are held stable.
- Requester rules: a requester must hold valid and its fields stable until ready. The block does not check this.
- Throughput: 1 op/cycle sustained when rsp_ready_i=1.
- Fairness: any continuously valid requester is granted within NUM_REQ issues.

Optional Feature:
- Macro: ALU_SHARE_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt_o (NUM_REQ x 16): per-requester saturating issue counters, reset to 0, incrementing on each issue for that requester and holding at 16'hFFFF.
  - Adds input stats_clr_i (1): synchronous clear of all counters. Clear wins over a same-cycle increment.
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Single op: reset, then req0 issues ALU_ADD a=5 b=7 rd=3 we=1 → req_ready_o=2'b01 same cycle; next cycle rsp_valid_o=1, rsp_id_o=0, rsp_addr_o=3, rsp_we_o=1, rsp_wdata_o=12.
- Contention: req0 and req1 both continuously valid, rsp_ready_i=1 → grants alternate 0,1,0,1; one response per cycle; each response's rsp_id_o and data match the issuer.
- Backpressure: rsp_ready_i=0 after the first response → req_ready_o=0 and rsp_* stable (ALU_SUB 10-3 → rsp_wdata_o=7 held). Raise rsp_ready_i → the held response drains and the next op issues in the same cycle.
- Wrap and idle: NUM_REQ=3, only req2 valid → granted; pointer→0. Next, req1 alone → granted. With no valid requesters, alu_rd_wr_en_o=0 and rsp_valid_o falls after drain.
- Reset mid-op: assert rst_i with rsp_valid_o=1 → rsp_valid_o=0 immediately (async). After release, req1 and req0 both valid → req0 wins (pointer=0).
- Stats (ALU_SHARE_ARB_STATS_EN): 3 issues by req1 → grant_cnt_o[1]=3. Pulse stats_clr_i → 0. Force 16'hFFFF then issue → counter stays at 16'hFFFF.

Source files
------------

// File: rtl/milano_pkg.sv
// Shared core types: ALU operator encoding used by the issue ports and the ALU.
package milano_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_opt_e;
endpackage

// File: rtl/alu_share_arb.sv
// Round-robin share of one combinational ALU among NUM_REQ requesters; result lands in a single tagged response slot.
// Latency: issue to rsp_valid_o is one cycle; 1 op/cycle sustained while rsp_ready_i=1.
// Backpressure: a full slot with rsp_ready_i=0 blocks every grant. ALU_SHARE_ARB_STATS_EN adds grant counters.
module alu_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  milano_pkg::alu_opt_e [NUM_REQ-1:0]   req_op_i,
    input  logic [NUM_REQ-1:0][31:0]             req_a_i,
    input  logic [NUM_REQ-1:0][31:0]             req_b_i,
    input  logic [NUM_REQ-1:0][4:0]              req_rd_addr_i,
    input  logic [NUM_REQ-1:0]                   req_rd_we_i,
    output milano_pkg::alu_opt_e                 alu_operator_o,
    output logic [31:0]                          alu_operand_a_o,
    output logic [31:0]                          alu_operand_b_o,
    output logic [4:0]                           alu_rd_addr_o,
    output logic                                 alu_rd_wr_en_o,
    input  logic                                 alu_reg_we_i,
    input  logic [4:0]                           alu_wr_addr_i,
    input  logic [31:0]                          alu_wdata_i,
`ifdef ALU_SHARE_ARB_STATS_EN
    input  logic                                 stats_clr_i,
    output logic [NUM_REQ-1:0][15:0]             grant_cnt_o,
`endif
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic [ID_W-1:0]                      rsp_id_o,
    output logic                                 rsp_we_o,
    output logic [4:0]                           rsp_addr_o,
    output logic [31:0]                          rsp_wdata_o
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;
    logic            hi_vld;
    logic            lo_vld;
    logic [ID_W-1:0] winner;
    logic            slot_free;
    logic            issue;

    // Rotating priority: lowest valid index at/above the pointer, else lowest valid overall (wrap).
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && !hi_vld && (i >= int'(rr_ptr))) begin
                hi_vld = 1'b1;
                hi_idx = ID_W'(i);
            end
            if (req_valid_i[i] && !lo_vld) begin
                lo_vld = 1'b1;
                lo_idx = ID_W'(i);
            end
        end
    end

    assign winner    = hi_vld ? hi_idx : lo_idx;
    assign slot_free = !rsp_valid_o || rsp_ready_i;
    assign issue     = lo_vld && slot_free && !rst_i;

    always_comb begin
        req_ready_o = '0;
        if (issue) begin
            req_ready_o = NUM_REQ'(1) << winner;
        end
    end

    // Idle ALU sees a harmless ADD 0+0 with no register write.
    always_comb begin
        alu_operator_o  = milano_pkg::ALU_ADD;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        alu_rd_addr_o   = '0;
        alu_rd_wr_en_o  = 1'b0;
        if (issue) begin
            alu_operator_o  = req_op_i[winner];
            alu_operand_a_o = req_a_i[winner];
            alu_operand_b_o = req_b_i[winner];
            alu_rd_addr_o   = req_rd_addr_i[winner];
            alu_rd_wr_en_o  = req_rd_we_i[winner];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_we_o    <= 1'b0;
            rsp_addr_o  <= '0;
            rsp_wdata_o <= '0;
        end else if (issue) begin
            rr_ptr      <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= winner;
            rsp_we_o    <= alu_reg_we_i;
            rsp_addr_o  <= alu_wr_addr_i;
            rsp_wdata_o <= alu_wdata_i;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q;

    // Clear has priority over a same-cycle issue; counters stick at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (stats_clr_i) begin
            cnt_q <= '0;
        end else if (issue && (cnt_q[winner] != 16'hFFFF)) begin
            cnt_q[winner] <= cnt_q[winner] + 16'd1;
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with NUM_REQ=3: directed scenarios followed by random traffic.
module tb_alu_share_arb;
    import milano_pkg::*;

    localparam int N   = 3;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    alu_opt_e [N-1:0]     req_op;
    logic [N-1:0][31:0]   req_a;
    logic [N-1:0][31:0]   req_b;
    logic [N-1:0][4:0]    req_rd;
    logic [N-1:0]         req_we;
    alu_opt_e             alu_op;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [4:0]           alu_rd;
    logic                 alu_wen;
    logic                 alu_reg_we;
    logic [4:0]           alu_wr_addr;
    logic [31:0]          alu_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_we;
    logic [4:0]           rsp_addr;
    logic [31:0]          rsp_wdata;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic                 stats_clr;
    logic [N-1:0][15:0]   grant_cnt;
`endif

    alu_share_arb #(.NUM_REQ(N)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .req_rd_addr_i  (req_rd),
        .req_rd_we_i    (req_we),
        .alu_operator_o (alu_op),
        .alu_operand_a_o(alu_a),
        .alu_operand_b_o(alu_b),
        .alu_rd_addr_o  (alu_rd),
        .alu_rd_wr_en_o (alu_wen),
        .alu_reg_we_i   (alu_reg_we),
        .alu_wr_addr_i  (alu_wr_addr),
        .alu_wdata_i    (alu_wdata),
`ifdef ALU_SHARE_ARB_STATS_EN
        .stats_clr_i    (stats_clr),
        .grant_cnt_o    (grant_cnt),
`endif
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_we_o       (rsp_we),
        .rsp_addr_o     (rsp_addr),
        .rsp_wdata_o    (rsp_wdata)
    );

    function automatic logic [31:0] alu_fn(input alu_opt_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            default: return {31'b0, ($signed(a) < $signed(b))};
        endcase
    endfunction

    // The shared ALU itself: purely combinational.
    always_comb alu_wdata = alu_fn(alu_op, alu_a, alu_b);
    assign alu_reg_we  = alu_wen;
    assign alu_wr_addr = alu_rd;

    typedef struct {
        int          id;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           m_ptr  = 0;
    bit           m_full = 1'b0;
    int           m_win;
    logic [N-1:0] m_rdy;
    logic [N-1:0] granted = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: decides each cycle's grant from the rotation rule and queues the expected response.
    always @(negedge clk) begin
        if (rst_i) begin
            chk("reset_req_ready", 32'(req_ready), 32'd0);
            m_ptr   = 0;
            m_full  = 1'b0;
            granted = '0;
            sb.delete();
        end else begin
            chk("rsp_valid_model", 32'(rsp_valid), 32'(m_full));
            m_win = -1;
            for (int k = 0; k < N; k++) begin
                if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
            end
            m_rdy = '0;
            if (m_win >= 0 && (!m_full || rsp_ready)) m_rdy[m_win] = 1'b1;
            chk("req_ready_model", 32'(req_ready), 32'(m_rdy));
            granted = m_rdy & req_valid;
            if (m_rdy != '0) begin
                chk("alu_a_mirror", alu_a, req_a[m_win]);
                chk("alu_op_mirror", 32'(alu_op), 32'(req_op[m_win]));
                sb.push_back('{m_win, req_we[m_win], req_rd[m_win],
                               alu_fn(req_op[m_win], req_a[m_win], req_b[m_win])});
                m_ptr  = (m_win + 1) % N;
                m_full = 1'b1;
            end else begin
                chk("alu_idle", {alu_wen, alu_rd, alu_a[12:0], alu_b[12:0]} | 32'(alu_op), 32'd0);
                if (rsp_ready) m_full = 1'b0;
            end
        end
    end

    // Monitor: every cycle the slot is full it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst_i && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data 0x%0h, expected no response", rsp_id, rsp_wdata);
            end else begin
                chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
                chk("rsp_we", 32'(rsp_we), 32'(sb[0].we));
                chk("rsp_addr", 32'(rsp_addr), 32'(sb[0].addr));
                chk("rsp_wdata", rsp_wdata, sb[0].wdata);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input alu_opt_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we);
        req_valid[r] = 1'b1;
        req_op[r]    = op;
        req_a[r]     = a;
        req_b[r]     = b;
        req_rd[r]    = rd;
        req_we[r]    = we;
    endtask

    logic [N-1:0] exp_rdy;

    initial begin
        rst_i     = 1'b1;
        rsp_ready = 1'b1;
`ifdef ALU_SHARE_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        for (int r = 0; r < N; r++) begin
            req_op[r] = ALU_ADD;
            req_a[r]  = 32'd0;
            req_b[r]  = 32'd0;
            req_rd[r] = 5'd0;
            req_we[r] = 1'b0;
        end
        req_valid = '1;
        #3;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_wdata", rsp_wdata, 32'd0);
        chk("reset_rsp_addr_we", {26'd0, rsp_addr, rsp_we}, 32'd0);
        chk("reset_ready_now", 32'(req_ready), 32'd0);
        step(2);
        req_valid = '0;
        rst_i     = 1'b0;

        // Single op
        drive(0, ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1);
        #1 chk("single_ready", 32'(req_ready), 32'b001);
        step(1);
        req_valid[0] = 1'b0;
        #1;
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd0);
        chk("single_rsp_addr", 32'(rsp_addr), 32'd3);
        chk("single_rsp_we", 32'(rsp_we), 32'd1);
        chk("single_rsp_wdata", rsp_wdata, 32'd12);

        // Contention: pointer sits at 1 after the single op
        drive(0, ALU_ADD, 32'd1, 32'd2, 5'd1, 1'b1);
        drive(1, ALU_XOR, 32'hF0F0, 32'h0FF0, 5'd2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            exp_rdy = (k % 2 == 0) ? 3'b010 : 3'b001;
            #1 chk("contend_ready", 32'(req_ready), 32'(exp_rdy));
            chk("contend_rsp_valid", 32'(rsp_valid), 32'd1);
            step(1);
        end
        req_valid = '0;

        // Backpressure
        drive(0, ALU_SUB, 32'd10, 32'd3, 5'd5, 1'b1);
        step(1);
        req_valid[0] = 1'b0;
        rsp_ready    = 1'b0;
        drive(1, ALU_ADD, 32'd4, 32'd4, 5'd6, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_wdata_held", rsp_wdata, 32'd7);
            step(1);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_drain_refill_ready", 32'(req_ready), 32'b010);
        step(1);
        req_valid[1] = 1'b0;
        #1;
        chk("bp_next_wdata", rsp_wdata, 32'd8);
        chk("bp_next_id", 32'(rsp_id), 32'd1);

        // Wrap and idle: pointer is 2
        drive(2, ALU_OR, 32'h00FF, 32'hFF00, 5'd7, 1'b1);
        #1 chk("wrap_req2_ready", 32'(req_ready), 32'b100);
        step(1);
        req_valid[2] = 1'b0;
        drive(0, ALU_AND, 32'hFFFF, 32'h0F0F, 5'd8, 1'b0);
        drive(1, ALU_SRL, 32'h8000, 32'd4, 5'd9, 1'b1);
        #1 chk("wrap_ptr_zero", 32'(req_ready), 32'b001);
        step(1);
        req_valid[0] = 1'b0;
        #1 chk("wrap_req1_ready", 32'(req_ready), 32'b010);
        step(1);
        req_valid = '0;
        #1;
        chk("idle_alu_wen", 32'(alu_wen), 32'd0);
        chk("idle_rsp_still_valid", 32'(rsp_valid), 32'd1);
        step(1);
        #1 chk("idle_rsp_drained", 32'(rsp_valid), 32'd0);

        // Reset mid-op with pointer away from 0
        drive(1, ALU_SLL, 32'd1, 32'd4, 5'd10, 1'b1);
        rsp_ready = 1'b0;
        step(1);
        req_valid = '0;
        #1 chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_i = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        chk("rst_async_valid", 32'(rsp_valid), 32'd0);
        chk("rst_async_ready", 32'(req_ready), 32'd0);
        step(1);
        rst_i     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        drive(0, ALU_ADD, 32'd100, 32'd1, 5'd11, 1'b1);
        drive(1, ALU_SUB, 32'd0, 32'd1, 5'd12, 1'b1);
        #1 chk("post_rst_req0_wins", 32'(req_ready), 32'b001);
        step(1);
        req_valid[0] = 1'b0;
        step(1);
        req_valid = '0;

`ifdef ALU_SHARE_ARB_STATS_EN
        stats_clr = 1'b1;
        step(1);
        stats_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, ALU_ADD, 32'(i), 32'd1, 5'd1, 1'b1);
            step(1);
        end
        req_valid = '0;
        #1 chk("stats_cnt1_three", 32'(grant_cnt[1]), 32'd3);
        chk("stats_cnt0_zero", 32'(grant_cnt[0]), 32'd0);
        stats_clr = 1'b1;
        step(1);
        stats_clr = 1'b0;
        #1 chk("stats_cleared", 32'(grant_cnt[1]), 32'd0);
        force dut.cnt_q = {16'h0000, 16'hFFFF, 16'h0000};
        #1 release dut.cnt_q;
        drive(1, ALU_ADD, 32'd1, 32'd1, 5'd1, 1'b1);
        step(1);
        req_valid = '0;
        #1 chk("stats_saturated", 32'(grant_cnt[1]), 32'h0000FFFF);
`endif

        // Random traffic; a requester keeps its fields until granted
        for (int c = 0; c < 600; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < N; r++) begin
                if (!req_valid[r] || granted[r]) begin
                    req_valid[r] = ($urandom_range(0, 2) != 0);
                    req_op[r]    = alu_opt_e'(3'($urandom_range(0, 7)));
                    req_a[r]     = $urandom;
                    req_b[r]     = $urandom;
                    req_rd[r]    = 5'($urandom_range(0, 31));
                    req_we[r]    = 1'($urandom_range(0, 1));
                end
            end
            step(1);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        step(3);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
